// File: rtl/ram_port_master.sv
// Burst initiator for one port of a synchronous dual-port RAM.
// Accepts write/read burst commands, streams write beats into consecutive
// RAM addresses and returns read beats one at a time over a valid/ready sink.
// All RAM controls and read-side outputs come straight from flops.

module ram_port_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  busy_o,
  output logic                  ram_cs_o,
  output logic                  ram_we_o,
  output logic                  ram_oe_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  inout  wire  [DATA_WIDTH-1:0] ram_data_io
);

  // Latency counter only needs to hold RD_LATENCY itself.
  localparam int LAT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_RESP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_oe_q, ram_oe_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  last_beat_s;

  // Handshake readiness is decoded from the state register only.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign wr_ready_o  = (state_q == ST_WRITE);
  assign busy_o      = (state_q != ST_IDLE);

  assign ram_cs_o    = ram_cs_q;
  assign ram_we_o    = ram_we_q;
  assign ram_oe_o    = ram_oe_q;
  assign ram_addr_o  = ram_addr_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

  // The bus is driven only during a write strobe; reset clears ram_we_q
  // asynchronously, so the bus is released the moment rst_n falls.
  assign ram_data_io = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign last_beat_s = (cnt_q == {LEN_WIDTH{1'b0}});

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_oe_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          cur_addr_d = cmd_addr_i;
          cnt_d      = cmd_len_i;
          state_d    = cmd_we_i ? ST_WRITE : ST_RD_ISSUE;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (wr_valid_i) begin
          ram_cs_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = cur_addr_q;
          wdata_d    = wr_data_i;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q - LEN_WIDTH'(1);
          state_d    = last_beat_s ? ST_IDLE : ST_WRITE;
        end else begin
          state_d    = ST_WRITE;
        end
      end

      ST_RD_ISSUE: begin
        ram_cs_d   = 1'b1;
        ram_oe_d   = 1'b1;
        ram_addr_d = cur_addr_q;
        lat_d      = LAT_W'(RD_LATENCY);
        state_d    = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        // lat_q reaches zero in cycle S+RD_LATENCY, when RAM data is valid.
        if (lat_q == {LAT_W{1'b0}}) begin
          rd_data_d  = ram_data_io;
          rd_valid_d = 1'b1;
          ram_oe_d   = 1'b0;
          state_d    = ST_RD_RESP;
        end else begin
          ram_oe_d   = 1'b1;
          lat_d      = lat_q - LAT_W'(1);
          state_d    = ST_RD_WAIT;
        end
      end

      ST_RD_RESP: begin
        if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          cnt_d      = cnt_q - LEN_WIDTH'(1);
          state_d    = last_beat_s ? ST_IDLE : ST_RD_ISSUE;
        end else begin
          state_d    = ST_RD_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= {ADDR_WIDTH{1'b0}};
      cnt_q      <= {LEN_WIDTH{1'b0}};
      lat_q      <= {LAT_W{1'b0}};
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      ram_addr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_oe_q   <= ram_oe_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master: table of bursts plus hand-written
// sequences for write gaps, read backpressure and mid-burst reset.

module tb_ram_port_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [5:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        busy;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [5:0]  ram_addr;
  wire  [31:0] ram_data;

  ram_port_master #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .LEN_WIDTH(4), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .busy_o(busy),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_oe_o(ram_oe),
    .ram_addr_o(ram_addr), .ram_data_io(ram_data)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple synchronous RAM model with one cycle read latency.
  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe;
  logic        rd_drive;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    rd_pipe  <= mem[ram_addr];
    rd_drive <= ram_cs && !ram_we;
  end
  assign ram_data = (rd_drive && ram_oe) ? rd_pipe : 32'hzzzz_zzzz;

  // Strobe monitor, sampled mid-cycle.
  typedef struct {
    logic        we;
    logic        oe;
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } strb_t;
  strb_t strobes[$];
  logic [31:0] rd_beats[$];
  int cyc_cnt = 0;
  int overlap_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    if (ram_cs) strobes.push_back('{ram_we, ram_oe, ram_addr, ram_data, cyc_cnt});
    if (ram_we && ram_oe) overlap_cnt <= overlap_cnt + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Present a command and hold it until accepted; waits = cycles stalled.
  task automatic issue_cmd(input logic we, input logic [5:0] a, input logic [3:0] l, output int waits);
    waits     = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("busy after accept", {63'd0, busy}, 64'd1);
  endtask

  // Stream len+1 write beats; pat bit (cycle%8) gives wr_valid per cycle.
  task automatic drive_write(input logic [3:0] len, input logic [31:0] base, input logic [7:0] pat);
    int   k;
    int   c;
    logic rdy;
    k = 0;
    c = 0;
    while (k <= int'(len) && c < 200) begin
      wr_valid = pat[c % 8];
      wr_data  = base + 32'(k);
      rdy      = wr_ready;
      @(posedge clk); #1;
      if (wr_valid && rdy) k++;
      c++;
    end
    wr_valid = 1'b0;
    chk("write beats accepted", 64'(k), 64'(int'(len) + 1));
  endtask

  // Accept n read beats with rd_ready held high.
  task automatic drive_read(input int n);
    int          k;
    int          c;
    logic        v;
    logic [31:0] d;
    k = 0;
    c = 0;
    rd_ready = 1'b1;
    while (k < n && c < 400) begin
      v = rd_valid;
      d = rd_data;
      @(posedge clk); #1;
      if (v && rd_ready) begin
        rd_beats.push_back(d);
        k++;
      end
      c++;
    end
    chk("read beats accepted", 64'(k), 64'(n));
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [3:0]  len;
    logic [31:0] base;
    logic [5:0]  exp_last_addr;
    logic [31:0] exp_last_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          w;
    int          c;
    int          nb;
    int          exp_gap;
    logic        stable;
    logic [31:0] d0;
    logic [5:0]  ea;

    vecs[0] = '{1'b1, 6'd4,  4'd3,  32'h0000_00A0, 6'd7,  32'h0000_00A3};
    vecs[1] = '{1'b0, 6'd4,  4'd3,  32'h0000_00A0, 6'd7,  32'h0000_00A3};
    vecs[2] = '{1'b1, 6'd62, 4'd3,  32'h0000_00B0, 6'd1,  32'h0000_00B3};
    vecs[3] = '{1'b0, 6'd62, 4'd3,  32'h0000_00B0, 6'd1,  32'h0000_00B3};
    vecs[4] = '{1'b1, 6'd16, 4'd15, 32'h0000_0100, 6'd31, 32'h0000_010F};
    vecs[5] = '{1'b0, 6'd16, 4'd15, 32'h0000_0100, 6'd31, 32'h0000_010F};
    vecs[6] = '{1'b1, 6'd40, 4'd0,  32'hDEAD_BEEF, 6'd40, 32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 6'd40, 4'd0,  32'hDEAD_BEEF, 6'd40, 32'hDEAD_BEEF};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 6'd0;
    cmd_len   = 4'd0;
    wr_valid  = 1'b0;
    wr_data   = 32'd0;
    rd_ready  = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst wr_ready",  {63'd0, wr_ready},  64'd0);
    chk("rst busy",      {63'd0, busy},      64'd0);
    chk("rst ram_cs",    {63'd0, ram_cs},    64'd0);
    chk("rst ram_we",    {63'd0, ram_we},    64'd0);
    chk("rst ram_oe",    {63'd0, ram_oe},    64'd0);
    chk("rst rd_valid",  {63'd0, rd_valid},  64'd0);
    chk("rst ram_addr",  64'(ram_addr),      64'd0);
    chk("rst rd_data",   64'(rd_data),       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of bursts.
    for (int i = 0; i < 8; i++) begin
      strobes.delete();
      rd_beats.delete();
      issue_cmd(vecs[i].we, vecs[i].addr, vecs[i].len, w);
      if (vecs[i].we) drive_write(vecs[i].len, vecs[i].base, 8'hFF);
      else drive_read(int'(vecs[i].len) + 1);
      repeat (3) @(posedge clk);
      #1;
      nb      = int'(vecs[i].len) + 1;
      exp_gap = vecs[i].we ? 1 : 4;
      chk($sformatf("v%0d strobe count", i), 64'(strobes.size()), 64'(nb));
      for (int k = 0; k < strobes.size(); k++) begin
        ea = vecs[i].addr + 6'(k);
        chk($sformatf("v%0d b%0d addr", i, k), 64'(strobes[k].addr), 64'(ea));
        chk($sformatf("v%0d b%0d we", i, k), {63'd0, strobes[k].we}, {63'd0, vecs[i].we});
        chk($sformatf("v%0d b%0d oe", i, k), {63'd0, strobes[k].oe}, {63'd0, ~vecs[i].we});
        if (vecs[i].we)
          chk($sformatf("v%0d b%0d wdata", i, k), 64'(strobes[k].data), 64'(vecs[i].base + 32'(k)));
        if (k > 0)
          chk($sformatf("v%0d b%0d spacing", i, k), 64'(strobes[k].cyc - strobes[k-1].cyc), 64'(exp_gap));
      end
      if (strobes.size() > 0)
        chk($sformatf("v%0d last addr", i), 64'(strobes[strobes.size()-1].addr), 64'(vecs[i].exp_last_addr));
      if (vecs[i].we && strobes.size() > 0)
        chk($sformatf("v%0d last wdata", i), 64'(strobes[strobes.size()-1].data), 64'(vecs[i].exp_last_data));
      if (!vecs[i].we) begin
        for (int k = 0; k < rd_beats.size(); k++)
          chk($sformatf("v%0d beat%0d rdata", i, k), 64'(rd_beats[k]), 64'(vecs[i].base + 32'(k)));
        if (rd_beats.size() > 0)
          chk($sformatf("v%0d last rdata", i), 64'(rd_beats[rd_beats.size()-1]), 64'(vecs[i].exp_last_data));
      end
      chk($sformatf("v%0d idle after", i), {63'd0, cmd_ready}, 64'd1);
      rd_ready = 1'b0;
    end

    // Write with gaps: wr_valid 1,0,1,0,1 -> three strobes two cycles apart.
    strobes.delete();
    issue_cmd(1'b1, 6'd20, 4'd2, w);
    drive_write(4'd2, 32'h0000_0055, 8'b0001_0101);
    repeat (3) @(posedge clk);
    #1;
    chk("gap strobe count", 64'(strobes.size()), 64'd3);
    for (int k = 0; k < strobes.size(); k++) begin
      chk($sformatf("gap b%0d addr", k), 64'(strobes[k].addr), 64'(20 + k));
      chk($sformatf("gap b%0d wdata", k), 64'(strobes[k].data), 64'(32'h55 + 32'(k)));
      if (k > 0) chk($sformatf("gap b%0d spacing", k), 64'(strobes[k].cyc - strobes[k-1].cyc), 64'd2);
    end

    // Read with rd_ready low for 5 cycles after the first beat appears.
    strobes.delete();
    rd_beats.delete();
    rd_ready = 1'b0;
    issue_cmd(1'b0, 6'd20, 4'd1, w);
    c = 0;
    while (!rd_valid && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("bp rd_valid up", {63'd0, rd_valid}, 64'd1);
    d0 = rd_data;
    nb = strobes.size();
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rd_valid !== 1'b1 || rd_data !== d0) stable = 1'b0;
    end
    chk("bp first beat data", 64'(d0), 64'h55);
    chk("bp held stable", {63'd0, stable}, 64'd1);
    chk("bp no new strobe", 64'(strobes.size()), 64'(nb));
    chk("bp strobes before accept", 64'(nb), 64'd1);
    drive_read(2);
    if (rd_beats.size() == 2) begin
      chk("bp beat0", 64'(rd_beats[0]), 64'h55);
      chk("bp beat1", 64'(rd_beats[1]), 64'h56);
    end
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Abort: reset during beat 2 of an 8-beat read.
    strobes.delete();
    rd_ready = 1'b1;
    issue_cmd(1'b0, 6'd16, 4'd7, w);
    c = 0;
    while (strobes.size() < 2 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("abort reached beat 2", 64'(strobes.size()), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort ram_cs",    {63'd0, ram_cs},    64'd0);
    chk("abort ram_we",    {63'd0, ram_we},    64'd0);
    chk("abort ram_oe",    {63'd0, ram_oe},    64'd0);
    chk("abort rd_valid",  {63'd0, rd_valid},  64'd0);
    chk("abort cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("abort busy",      {63'd0, busy},      64'd0);
    strobes.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort no strobes", 64'(strobes.size()), 64'd0);
    rst_n = 1'b1;
    rd_beats.delete();
    issue_cmd(1'b0, 6'd16, 4'd0, w);
    chk("abort new cmd waits", 64'(w), 64'd0);
    drive_read(1);
    if (rd_beats.size() == 1) chk("abort new cmd data", 64'(rd_beats[0]), 64'h100);
    repeat (2) @(posedge clk);
    #1;
    chk("post abort strobes", 64'(strobes.size()), 64'd1);

    chk("no we&oe overlap", 64'(overlap_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
